// File: rtl/cdb_arbiter_if.sv
// Bundles the two producer result streams and the common data bus broadcast.
// The master side is the producers plus the snooping consumers; the slave side is the arbiter.
interface cdb_arbiter_if #(
  parameter int LAB_W = 5,
  parameter int VAL_W = 32
);
  logic             alu_en;
  logic [LAB_W-1:0] alu_lab;
  logic [VAL_W-1:0] alu_val;
  logic             lsb_en;
  logic [LAB_W-1:0] lsb_lab;
  logic [VAL_W-1:0] lsb_val;
  logic             alu_afull;
  logic             lsb_afull;
  logic             cdb_en;
  logic [LAB_W-1:0] cdb_lab;
  logic [VAL_W-1:0] cdb_val;
  logic             cdb_src;
  logic             ovf_err;

  modport master (
    output alu_en, alu_lab, alu_val, lsb_en, lsb_lab, lsb_val,
    input  alu_afull, lsb_afull, cdb_en, cdb_lab, cdb_val, cdb_src, ovf_err
  );

  modport slave (
    input  alu_en, alu_lab, alu_val, lsb_en, lsb_lab, lsb_val,
    output alu_afull, lsb_afull, cdb_en, cdb_lab, cdb_val, cdb_src, ovf_err
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one FIFO per result source (ALU, LSB), round-robin
// selection of the FIFO heads, and a registered single-entry broadcast per cycle.
// Index 0 of every per-source array is the ALU, index 1 the LSB.
module cdb_arbiter #(
  parameter int DEPTH = 4,
  parameter int LAB_W = 5,
  parameter int VAL_W = 32
) (
  input  logic         clk,
  input  logic         rst_in,
  input  logic         rdy_in,
  input  logic         flush,
  cdb_arbiter_if.slave bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSB = 1'b1
  } src_e;

  logic [LAB_W-1:0] lab_mem [2][DEPTH];
  logic [VAL_W-1:0] val_mem [2][DEPTH];
  logic [PTR_W-1:0] wr_ptr  [2];
  logic [PTR_W-1:0] rd_ptr  [2];
  logic [CNT_W-1:0] count   [2];
  src_e             last_grant;

  logic [LAB_W-1:0] in_lab [2];
  logic [VAL_W-1:0] in_val [2];
  logic [1:0]       in_en;
  logic [1:0]       non_empty;
  logic [1:0]       full;
  logic [1:0]       take;
  logic [1:0]       push;
  logic [1:0]       pop;
  logic             grant_vld;
  src_e             grant;
  logic             ovf_hit;
  logic             active;
  logic [LAB_W-1:0] head_lab;
  logic [VAL_W-1:0] head_val;

  // Gather the two producer streams into indexable form.
  always_comb begin
    in_en     = {bus.lsb_en, bus.alu_en};
    in_lab[0] = bus.alu_lab;
    in_lab[1] = bus.lsb_lab;
    in_val[0] = bus.alu_val;
    in_val[1] = bus.lsb_val;
  end

  // Arbitrate on the pre-edge FIFO heads and decide this edge's pushes/pops.
  // A full FIFO still accepts a push when its head is popped at the same edge.
  always_comb begin
    active = rdy_in & ~flush;
    for (int unsigned s = 0; s < 2; s++) begin
      non_empty[s] = (count[s] != '0);
      full[s]      = (count[s] == CNT_W'(DEPTH));
      take[s]      = active & in_en[s] & (in_lab[s] != '0);
    end
    grant_vld = |non_empty;
    if (&non_empty)
      grant = (last_grant == SRC_ALU) ? SRC_LSB : SRC_ALU;
    else if (non_empty[1])
      grant = SRC_LSB;
    else
      grant = SRC_ALU;
    pop[0]  = active & grant_vld & (grant == SRC_ALU);
    pop[1]  = active & grant_vld & (grant == SRC_LSB);
    push    = take & (~full | pop);
    ovf_hit = |(take & full & ~pop);
    head_lab = (grant == SRC_LSB) ? lab_mem[1][rd_ptr[1]] : lab_mem[0][rd_ptr[0]];
    head_val = (grant == SRC_LSB) ? val_mem[1][rd_ptr[1]] : val_mem[0][rd_ptr[0]];
  end

  // FIFO storage: written on accepted pushes only, contents need no reset.
  always_ff @(posedge clk) begin
    for (int unsigned s = 0; s < 2; s++) begin
      if (push[s]) begin
        lab_mem[s][wr_ptr[s]] <= in_lab[s];
        val_mem[s][wr_ptr[s]] <= in_val[s];
      end
    end
  end

  // FIFO pointers, occupancy and round-robin history.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      for (int unsigned s = 0; s < 2; s++) begin
        wr_ptr[s] <= '0;
        rd_ptr[s] <= '0;
        count[s]  <= '0;
      end
      last_grant <= SRC_LSB;
    end else if (rdy_in) begin
      if (flush) begin
        for (int unsigned s = 0; s < 2; s++) begin
          wr_ptr[s] <= '0;
          rd_ptr[s] <= '0;
          count[s]  <= '0;
        end
        last_grant <= SRC_LSB;
      end else begin
        for (int unsigned s = 0; s < 2; s++) begin
          if (push[s]) wr_ptr[s] <= wr_ptr[s] + 1'b1;
          if (pop[s])  rd_ptr[s] <= rd_ptr[s] + 1'b1;
          case ({push[s], pop[s]})
            2'b10:   count[s] <= count[s] + 1'b1;
            2'b01:   count[s] <= count[s] - 1'b1;
            default: count[s] <= count[s];
          endcase
        end
        if (grant_vld) last_grant <= grant;
      end
    end
  end

  // Registered broadcast; label/value/source hold when nothing is granted.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      bus.cdb_en  <= 1'b0;
      bus.cdb_lab <= '0;
      bus.cdb_val <= '0;
      bus.cdb_src <= 1'b0;
    end else if (rdy_in) begin
      if (flush) begin
        bus.cdb_en <= 1'b0;
      end else if (grant_vld) begin
        bus.cdb_en  <= 1'b1;
        bus.cdb_lab <= head_lab;
        bus.cdb_val <= head_val;
        bus.cdb_src <= (grant == SRC_LSB);
      end else begin
        bus.cdb_en <= 1'b0;
      end
    end
  end

  // Sticky overflow flag, survives flush, cleared only by reset.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in)
      bus.ovf_err <= 1'b0;
    else if (ovf_hit)
      bus.ovf_err <= 1'b1;
  end

  assign bus.alu_afull = (count[0] >= CNT_W'(DEPTH - 1));
  assign bus.lsb_afull = (count[1] >= CNT_W'(DEPTH - 1));

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_cdb_arbiter;
  localparam int DEPTH = 4;
  localparam int LAB_W = 5;
  localparam int VAL_W = 32;

  logic clk    = 1'b0;
  logic rst_in = 1'b0;
  logic rdy_in = 1'b0;
  logic flush  = 1'b0;

  cdb_arbiter_if #(.LAB_W(LAB_W), .VAL_W(VAL_W)) bus ();

  cdb_arbiter #(.DEPTH(DEPTH), .LAB_W(LAB_W), .VAL_W(VAL_W)) dut (
    .clk    (clk),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .flush  (flush),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [LAB_W-1:0] lab;
    logic [VAL_W-1:0] val;
  } ent_t;

  ent_t             qa[$];
  ent_t             ql[$];
  ent_t             m_e;
  logic             m_en   = 1'b0;
  logic [LAB_W-1:0] m_lab  = '0;
  logic [VAL_W-1:0] m_val  = '0;
  logic             m_src  = 1'b0;
  logic             m_ovf  = 1'b0;
  logic             m_last = 1'b1;
  logic             m_sel;

  always @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      qa.delete(); ql.delete();
      m_en = 0; m_lab = '0; m_val = '0; m_src = 0; m_ovf = 0; m_last = 1;
    end else if (rdy_in) begin
      if (flush) begin
        qa.delete(); ql.delete();
        m_en = 0; m_last = 1;
      end else begin
        if (qa.size() != 0 || ql.size() != 0) begin
          if (qa.size() != 0 && ql.size() != 0) m_sel = ~m_last;
          else m_sel = (ql.size() != 0);
          m_e = m_sel ? ql.pop_front() : qa.pop_front();
          m_en = 1; m_lab = m_e.lab; m_val = m_e.val; m_src = m_sel; m_last = m_sel;
        end else begin
          m_en = 0;
        end
        if (bus.alu_en && bus.alu_lab != 0) begin
          if (qa.size() < DEPTH) qa.push_back('{lab: bus.alu_lab, val: bus.alu_val});
          else m_ovf = 1;
        end
        if (bus.lsb_en && bus.lsb_lab != 0) begin
          if (ql.size() < DEPTH) ql.push_back('{lab: bus.lsb_lab, val: bus.lsb_val});
          else m_ovf = 1;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("m_cdb_en", bus.cdb_en, m_en);
    chk("m_cdb_lab", bus.cdb_lab, m_lab);
    chk("m_cdb_val", bus.cdb_val, m_val);
    chk("m_cdb_src", bus.cdb_src, m_src);
    chk("m_ovf_err", bus.ovf_err, m_ovf);
    chk("m_alu_afull", bus.alu_afull, qa.size() >= DEPTH - 1);
    chk("m_lsb_afull", bus.lsb_afull, ql.size() >= DEPTH - 1);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic ae, input logic [LAB_W-1:0] al, input logic [VAL_W-1:0] av,
                       input logic le, input logic [LAB_W-1:0] ll, input logic [VAL_W-1:0] lv);
    bus.alu_en = ae; bus.alu_lab = al; bus.alu_val = av;
    bus.lsb_en = le; bus.lsb_lab = ll; bus.lsb_val = lv;
  endtask

  task automatic idle;
    drive(0, '0, '0, 0, '0, '0);
  endtask

  task automatic do_flush;
    flush = 1; tick; flush = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  logic [LAB_W-1:0] seen[$];
  logic [LAB_W-1:0] exp2[6];
  int               en_run;
  logic             saw24;

  initial begin
    idle;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_cdb_en", bus.cdb_en, 0);
    chk("rst_ovf", bus.ovf_err, 0);
    chk("rst_afull", {bus.alu_afull, bus.lsb_afull}, 2'b00);
    rst_in = 1; rdy_in = 1;
    tick;

    // 1: single ALU result, one-cycle latency then idle
    drive(1, 5'd3, 32'h11, 0, '0, '0);
    tick;
    idle;
    chk("t1_no_bypass", bus.cdb_en, 0);
    tick;
    chk("t1_en", bus.cdb_en, 1);
    chk("t1_lab", bus.cdb_lab, 5'd3);
    chk("t1_val", bus.cdb_val, 32'h11);
    chk("t1_src", bus.cdb_src, 0);
    tick;
    chk("t1_en_low", bus.cdb_en, 0);

    // 2: simultaneous streams interleave, ALU first after history reset
    do_flush;
    seen.delete(); en_run = 0;
    for (int i = 0; i < 8; i++) begin
      if (i < 3) drive(1, 5'(1 + i), 32'(16 + i), 1, 5'(9 + i), 32'(32 + i));
      else idle;
      tick;
      if (bus.cdb_en) begin seen.push_back(bus.cdb_lab); en_run++; end
    end
    exp2 = '{5'd1, 5'd9, 5'd2, 5'd10, 5'd3, 5'd11};
    chk("t2_count", seen.size(), 6);
    chk("t2_run", en_run, 6);
    for (int i = 0; i < 6 && i < seen.size(); i++) chk("t2_order", seen[i], exp2[i]);

    // 3: both sources push every cycle until the LSB FIFO overflows
    do_flush;
    seen.delete();
    for (int i = 1; i <= 8; i++) begin
      drive(1, 5'(i), 32'(i * 3), 1, 5'(16 + i), 32'(i * 7));
      tick;
      if (bus.cdb_en) seen.push_back(bus.cdb_lab);
      if (i == 4) begin
        chk("t3_alu_afull_lo", bus.alu_afull, 0);
        chk("t3_lsb_afull_hi", bus.lsb_afull, 1);
      end
      if (i == 5) chk("t3_alu_afull_hi", bus.alu_afull, 1);
      if (i == 7) chk("t3_ovf_lo", bus.ovf_err, 0);
      if (i == 8) chk("t3_ovf_hi", bus.ovf_err, 1);
    end
    idle;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (!bus.cdb_en) break;
      seen.push_back(bus.cdb_lab);
    end
    chk("t3_drained", bus.cdb_en, 0);
    chk("t3_count", seen.size(), 15);
    saw24 = 0;
    foreach (seen[i]) if (seen[i] == 5'd24) saw24 = 1;
    chk("t3_lost_label", saw24, 0);

    // 4: flush with loaded FIFOs and a same-edge push
    do_flush;
    for (int i = 0; i < 3; i++) begin
      drive(1, 5'(1 + i), 32'(i), 1, 5'(9 + i), 32'(i));
      tick;
    end
    chk("t4_pre_en", bus.cdb_en, 1);
    drive(1, 5'd7, 32'h77, 0, '0, '0);
    flush = 1;
    tick;
    flush = 0; idle;
    chk("t4_en", bus.cdb_en, 0);
    chk("t4_afull", {bus.alu_afull, bus.lsb_afull}, 2'b00);
    chk("t4_ovf_kept", bus.ovf_err, 1);
    tick;
    chk("t4_en_after", bus.cdb_en, 0);
    drive(1, 5'd12, 32'hC0, 0, '0, '0);
    tick;
    idle;
    tick;
    chk("t4_resume_en", bus.cdb_en, 1);
    chk("t4_resume_lab", bus.cdb_lab, 5'd12);
    chk("t4_resume_val", bus.cdb_val, 32'hC0);

    // 5: stall while broadcasting lab 5
    drive(1, 5'd5, 32'h55, 0, '0, '0);
    tick;
    drive(1, 5'd6, 32'h66, 0, '0, '0);
    tick;
    chk("t5_lab5", bus.cdb_lab, 5'd5);
    rdy_in = 0;
    drive(1, 5'd13, 32'hD, 1, 5'd14, 32'hE);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("t5_hold_en", bus.cdb_en, 1);
      chk("t5_hold_lab", bus.cdb_lab, 5'd5);
      chk("t5_hold_val", bus.cdb_val, 32'h55);
    end
    rdy_in = 1; idle;
    tick;
    chk("t5_next_lab", bus.cdb_lab, 5'd6);
    chk("t5_next_val", bus.cdb_val, 32'h66);
    tick;
    chk("t5_empty", bus.cdb_en, 0);

    // 6: asynchronous reset mid-burst, then a label-0 result
    for (int i = 0; i < 3; i++) begin
      drive(1, 5'(20 + i), 32'(i), 0, '0, '0);
      tick;
    end
    idle;
    chk("t6_pre_en", bus.cdb_en, 1);
    #1 rst_in = 0;
    #1;
    chk("t6_async_en", bus.cdb_en, 0);
    chk("t6_async_lab", bus.cdb_lab, 0);
    chk("t6_async_val", bus.cdb_val, 0);
    chk("t6_async_ovf", bus.ovf_err, 0);
    #1 rst_in = 1;
    drive(1, 5'd0, 32'hBAD, 0, '0, '0);
    tick;
    idle;
    tick;
    chk("t6_lab0_en", bus.cdb_en, 0);
    tick;
    chk("t6_lab0_en2", bus.cdb_en, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
